// File: rtl/ps2_pkg.sv
// Shared key indices, Set-2 scancode constants, receiver FSM states and the
// scancode-to-key lookup for the PS/2 keycode decoder.
package ps2_pkg;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_JUMP  = 4;
    localparam int NUM_KEYS  = 5;

    localparam logic [7:0] SC_E0        = 8'hE0;
    localparam logic [7:0] SC_F0        = 8'hF0;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    // One-hot key mask for {E0 prefix, code}; all-zero for unmapped codes.
    function automatic logic [NUM_KEYS-1:0] key_mask(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        if (ext) begin
            case (code)
                SC_EXT_LEFT:  mask[KEY_LEFT]  = 1'b1;
                SC_EXT_RIGHT: mask[KEY_RIGHT] = 1'b1;
                SC_EXT_UP:    mask[KEY_UP]    = 1'b1;
                SC_EXT_DOWN:  mask[KEY_DOWN]  = 1'b1;
                default:      mask = '0;
            endcase
        end else begin
            case (code)
                SC_A:     mask[KEY_LEFT]  = 1'b1;
                SC_D:     mask[KEY_RIGHT] = 1'b1;
                SC_W:     mask[KEY_UP]    = 1'b1;
                SC_S:     mask[KEY_DOWN]  = 1'b1;
                SC_SPACE: mask[KEY_JUMP]  = 1'b1;
                default:  mask = '0;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for the PS/2 clock line;
// emits a single-cycle strobe when the filtered level falls.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic [1:0]    sync_reg;
    logic          level_reg;
    logic [CW-1:0] run_cnt_reg;
    logic          fall_reg;
    logic          sync_bit;
    logic          run_done;

    assign sync_bit = sync_reg[1];
    assign run_done = (run_cnt_reg == CW'(FILTER_LEN - 1));
    assign fall     = fall_reg;

    // The counter tracks how long the synchronised line has disagreed with the filtered level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg    <= 2'b11;
            level_reg   <= 1'b1;
            run_cnt_reg <= '0;
            fall_reg    <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], line};
            fall_reg <= 1'b0;
            if (sync_bit == level_reg) begin
                run_cnt_reg <= '0;
            end else if (run_done) begin
                run_cnt_reg <= '0;
                level_reg   <= sync_bit;
                fall_reg    <= level_reg & ~sync_bit;
            end else begin
                run_cnt_reg <= run_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 Set-2 receiver: frames bytes off the keyboard, tracks E0/F0 prefixes and
// keeps a held-key bitmask for the game keys.
module ps2_keycode_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keycode,
    output logic       keyPress,
    output logic [7:0] scancode,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state_reg, state_next;
    logic [1:0]    data_sync_reg;
    logic          data_bit;
    logic          fall;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          parity_reg;
    logic [TW-1:0] idle_cnt_reg;
    logic          e0_reg, f0_reg;
    logic [4:0]    keycode_reg, keycode_next;
    logic          key_press_reg;
    logic [7:0]    scancode_reg;
    logic          scan_valid_reg;
    logic          frame_err_reg;
    logic          timeout;
    logic          frame_good;
    logic          frame_error;
    logic          is_prefix;
    logic [4:0]    mask;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk (Clk),
        .rst (Reset),
        .line(ps2_clk),
        .fall(fall)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) data_sync_reg <= 2'b11;
        else       data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
    assign data_bit = data_sync_reg[1];

    // A fall strobe in the same cycle wins over the timeout.
    assign timeout = (state_reg != ST_IDLE) && !fall && (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (timeout) begin
            state_next = ST_IDLE;
        end else if (fall) begin
            case (state_reg)
                ST_IDLE:   if (!data_bit) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_good  = 1'b0;
        frame_error = timeout;
        if (fall && state_reg == ST_IDLE && data_bit) frame_error = 1'b1;
        if (fall && state_reg == ST_STOP) begin
            frame_good  = data_bit & (^{shift_reg, parity_reg});
            frame_error = ~frame_good;
        end
    end

    assign is_prefix = (shift_reg == SC_E0) || (shift_reg == SC_F0);
    assign mask      = key_mask(e0_reg, shift_reg);

    always_comb begin
        keycode_next = keycode_reg;
        if (frame_good && !is_prefix) begin
            keycode_next = f0_reg ? (keycode_reg & ~mask) : (keycode_reg | mask);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            idle_cnt_reg   <= '0;
            e0_reg         <= 1'b0;
            f0_reg         <= 1'b0;
            keycode_reg    <= '0;
            key_press_reg  <= 1'b0;
            scancode_reg   <= '0;
            scan_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            scan_valid_reg <= 1'b0;
            frame_err_reg  <= frame_error;
            keycode_reg    <= keycode_next;
            key_press_reg  <= |keycode_next;

            if (fall || timeout || state_reg == ST_IDLE) idle_cnt_reg <= '0;
            else                                         idle_cnt_reg <= idle_cnt_reg + 1'b1;

            if (fall) begin
                case (state_reg)
                    ST_IDLE:   bit_cnt_reg <= '0;
                    ST_DATA: begin
                        shift_reg   <= {data_bit, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    ST_PARITY: parity_reg <= data_bit;
                    default:   ;
                endcase
            end

            if (frame_error) begin
                e0_reg <= 1'b0;
                f0_reg <= 1'b0;
            end else if (frame_good) begin
                if (shift_reg == SC_E0) begin
                    e0_reg <= 1'b1;
                end else if (shift_reg == SC_F0) begin
                    f0_reg <= 1'b1;
                end else begin
                    scancode_reg   <= shift_reg;
                    scan_valid_reg <= 1'b1;
                    e0_reg         <= 1'b0;
                    f0_reg         <= 1'b0;
                end
            end
        end
    end

    assign keycode    = keycode_reg;
    assign keyPress   = key_press_reg;
    assign scancode   = scancode_reg;
    assign scan_valid = scan_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: doc/ps2_keycode_decoder.md
Name: ps2_keycode_decoder

Overview:
Receives PS/2 Set-2 scancodes from the keyboard and produces the held-key bitmask `keycode[4:0]` and the `keyPress` flag consumed by the Player block. It is the producing end of the keycode interface.
- Covers line synchronisation, glitch filtering, 11-bit frame reception with parity/stop checking, stall timeout, and E0/F0 prefix handling.
- Maps scancodes to game keys and keeps a make/break held state per key.

Parameters:
FILTER_LEN, 8, consecutive equal synchronised samples required before the filtered ps2_clk level changes
TIMEOUT_CYCLES, 50000, Clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
Clk  in  1  system clock, the single clock domain
Reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock line, asynchronous
ps2_data  in  1  raw PS/2 data line, asynchronous
keycode  out  5  held-key bitmask: [0] LEFT, [1] RIGHT, [2] UP, [3] DOWN, [4] JUMP
keyPress  out  1  OR of keycode bits, registered
scancode  out  8  last valid non-prefix byte (debug)
scan_valid  out  1  one-cycle pulse when scancode updates
frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
Reset:
- Reset is asynchronous and active-high. While asserted, all outputs are 0, the FSM is in IDLE, and the prefix flags and counters are cleared.
- The filtered clock level resets to 1.

Input conditioning:
- ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- The filtered clock level changes only after FILTER_LEN consecutive identical synchronised samples.
- A falling edge is a filtered transition 1->0. It is a single-cycle strobe.
- ps2_data is sampled (synchronised value) on that strobe.

FSM (IDLE, DATA, PARITY, STOP):
- IDLE: on a fall strobe, if data=0 go to DATA with the bit counter at 0. If data=1, pulse frame_err and stay in IDLE.
- DATA: on each fall strobe, shift the bit in LSB-first. After the 8th bit go to PARITY.
- PARITY: on a fall strobe, capture the parity bit and go to STOP.
- STOP: on a fall strobe, the frame is good if data=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Good frame: process the byte. Bad frame: pulse frame_err. Return to IDLE in either case.
- Timeout: an idle counter resets on every fall strobe and counts only outside IDLE. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, frame_err pulses, and the partial byte is discarded.
- Any frame error also clears the E0 and F0 flags.

Byte processing (cycle after the good stop bit is seen):
- 0xE0: set e0_seen; no output change.
- 0xF0: set f0_seen; no output change.
- Any other byte:
  - scancode <= byte and scan_valid pulses.
  - A lookup of {e0_seen, byte} gives the key index.
  - If f0_seen is 0 (make), set the keycode bit. If f0_seen is 1 (break), clear it.
  - Unmapped codes change no keycode bit but still pulse scan_valid.
  - Both prefix flags clear.

Key map:
- LEFT: 0x1C (A) or E0 0x6B
- RIGHT: 0x23 (D) or E0 0x74
- UP: 0x1D (W) or E0 0x75
- DOWN: 0x1B (S) or E0 0x72
- JUMP: 0x29 (space)
- 0x6B without E0 (keypad 4) is unmapped.

Timing and edge cases:
- keyPress is registered from the next-state keycode, so it changes in the same cycle as keycode.
- Latency from the stop-bit fall strobe to a keycode update is 1 Clk cycle.
- Typematic repeats re-set an already-set bit; this is not an error.
- A break for a key that is not held is a no-op.
- LEFT and RIGHT may both be 1; no arbitration is done here.

Decomposition:
Shared package ps2_pkg holds:
- key-index constants (KEY_LEFT=0 … KEY_JUMP=4);
- scancode constants (SC_E0, SC_F0 and the mapped codes);
- the FSM state typedef.

Sub-module ps2_line_filter (synchroniser, FILTER_LEN filter, fall-strobe generation) is instantiated for ps2_clk. The data line uses the synchroniser only.

Test Plan:
1. Send frame 0x1C with correct parity, then nothing -> scan_valid pulses once, scancode=0x1C, keycode=5'b00001, keyPress=1 one cycle after the stop strobe.
2. Send 0x1C, then F0 1C -> keycode returns to 0 and keyPress drops to 0. No scan_valid on the F0 byte; scan_valid pulses on the final 0x1C.
3. Send E0 74, then 29 -> keycode=5'b10010. Then E0 F0 74 -> keycode=5'b10000.
4. Send 0x23 with the parity bit inverted -> frame_err pulses once, keycode unchanged, e0/f0 flags cleared. A following good 0x23 sets keycode[1].
5. Send start + 4 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses and the FSM is in IDLE. A following full 0x1D frame sets keycode[2].
6. Insert 3-cycle low glitches on ps2_clk (FILTER_LEN=8) during IDLE -> no strobe and no frame_err. Assert Reset mid-frame -> all outputs 0 immediately, and the next clean frame decodes correctly.
